truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequencer that drives an external N_IN-input, single-output combinational function-under-test (FUT), such as a restricted or reduced benchmark netlist, through all 2^N_IN input vectors in ascending order. It captures the FUT output into a packed truth table and counts its on-set. It sits between the benchmark netlists and the characterisation/equivalence harness, so restricted functions can be checked in hardware against their golden tables.

## Interface
- N_IN, default 6: FUT input count; legal range 1..8.
- SETTLE, default 1: cycles each vector is held before sampling; must be ≥1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- abort  in  1  stops a sweep in progress.
- fut_x  out  N_IN  vector applied to the FUT.
- fut_y  in  1  FUT output.
- busy  out  1  high in DRIVE.
- done  out  1  one-cycle pulse when a sweep completes.
- tt  out  2^N_IN  captured truth table; bit m = fut_y for fut_x=m.
- ones  out  N_IN+1  count of 1s captured in the current sweep.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 → DRIVE.
  - On acceptance, minterm index m, the settle counter, tt and ones all clear to 0.
- DRIVE:
  - fut_x=m.
  - The settle counter counts 0..SETTLE-1.
  - On the edge at count SETTLE-1: tt[m]←fut_y, ones←ones+fut_y, counter←0.
  - If m=2^N_IN-1 → DONE; else m←m+1.
- DONE: done=1 for one cycle, then → IDLE. tt and ones hold until the next accepted start.
- start while in DRIVE or DONE is ignored.
- abort:
  - In DRIVE, abort=1 → IDLE on the next edge. done is not pulsed.
  - tt and ones keep their partial contents. The bit for the minterm being sampled in that cycle is not written.
  - abort in IDLE or DONE has no effect.
  - abort has priority over the sample and the state transition.
- fut_x outside DRIVE: held at its last value, or 0 after reset.
- Arithmetic: m is N_IN bits and never wraps, because the terminal check precedes the increment. ones saturates naturally at 2^N_IN within N_IN+1 bits.

## Timing
- Reset values: state=IDLE; fut_x=0, busy=0, done=0, tt=0, ones=0; internal m=0 and counter=0.
- Reset mid-sweep: all of the above takes effect immediately (asynchronous). The sweep is lost.
- start accepted at edge T0: busy=1 and fut_x=0 from T0.
- Vector m is applied during cycles T0+m·SETTLE .. T0+(m+1)·SETTLE-1. It is sampled on the last edge of that window.
- done is high during cycle T0+2^N_IN·SETTLE. For N_IN=6, SETTLE=1 that is 64 cycles after acceptance.
- busy falls in the same cycle that done rises.
- tt/ones are stable and final while done=1.
- Back-to-back sweeps: start asserted during the done cycle is ignored. The earliest next acceptance is the following IDLE cycle.
- The FUT is purely combinational. SETTLE covers any external pipeline or registering of fut_y.

## Configuration
- TT_COMPARE_EN:
  - When defined, adds input golden (2^N_IN), and outputs mismatch (1) and first_bad (N_IN).
  - At each sample, if fut_y≠golden[m] and mismatch=0: mismatch←1 and first_bad←m.
  - Both clear on start acceptance and reset. Both are valid during done.
- Without TT_COMPARE_EN: none of these ports or registers exist. Behaviour is otherwise identical.

## Structure
- Package truth_table_pkg holds:
  - the state enum (IDLE, DRIVE, DONE);
  - the width helper constants TT_W=2^N_IN and CNT_W=N_IN+1, as parameterised functions;
  - the legal-range limits for N_IN and SETTLE.
- One sub-module, tt_settle_counter: SETTLE-modulo counter with clear and a terminal-count flag. The FSM, capture and compare logic stay in the top block.

## Test plan
- Parity sweep: N_IN=6, SETTLE=1, fut_y=^fut_x, start pulse → done 64 cycles after acceptance, tt=0x6996966996696996, ones=32.
- Constant and settle: fut_y=0, SETTLE=3 → done at 192 cycles, tt=0, ones=0, each fut_x value held exactly 3 cycles.
- Busy start: start re-pulsed at cycles 5 and 40 of a sweep → ignored; single done at cycle 64; tt unchanged from the parity result.
- Abort: fut_y=1, abort at the edge where m=10 → IDLE next cycle, no done, tt=0x3FF, ones=10.
- Reset mid-sweep: rst asserted at m=20 → fut_x, busy, done, tt, ones all 0 immediately. A new start afterwards yields the full correct parity table.
- Compare (TT_COMPARE_EN): golden = parity table with bits 5 and 9 flipped → mismatch=1, first_bad=5 at done. With the exact golden → mismatch=0.

Source files
------------

// File: rtl/truth_table_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_pkg
//
// Shared definitions for the truth-table sweeper:
//   - state_e       : sequencer states (IDLE, DRIVE, DONE)
//   - tt_w()        : truth-table width for a given input count (2^n_in)
//   - cnt_w()       : on-set counter width for a given input count (n_in+1)
//   - settle_cnt_w(): register width of the settle counter for a SETTLE value
//   - legal-range limits for N_IN and SETTLE
// -----------------------------------------------------------------------------
package truth_table_pkg;

  localparam int N_IN_MIN   = 1;
  localparam int N_IN_MAX   = 8;
  localparam int SETTLE_MIN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One table bit per minterm.
  function automatic int tt_w(input int n_in);
    return 1 << n_in;
  endfunction

  // Needs one extra bit so an all-ones function (2^n_in) fits.
  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

  // A SETTLE of 1 still gets a 1-bit register so the counter has a legal width.
  function automatic int settle_cnt_w(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// -----------------------------------------------------------------------------
// tt_settle_counter
//
// Modulo-SETTLE counter that paces the sweeper: it counts 0..SETTLE-1 while
// enabled and flags the terminal count, which is the cycle on which the
// function-under-test output is sampled.
//
// Ports:
//   clk      in  rising-edge clock
//   rst      in  asynchronous active-high reset
//   i_clear  in  synchronous clear to 0 (takes priority over i_en)
//   i_en     in  advance the count
//   o_tc     out count is at SETTLE-1 (combinational from the register)
// -----------------------------------------------------------------------------
module tt_settle_counter
  import truth_table_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam int            CW   = settle_cnt_w(SETTLE);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] r_count;

  assign o_tc = (r_count == LAST);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      if (o_tc) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Drives an external N_IN-input, single-output combinational function through
// every input vector 0..2^N_IN-1 in ascending order, holding each vector for
// SETTLE cycles and sampling the function output on the last cycle of that
// window. The samples build a packed truth table (bit m = f(m)) and an on-set
// count. A sweep can be aborted, leaving the partial table in place.
//
// Parameters:
//   N_IN    function input count, 1..8
//   SETTLE  cycles each vector is held before it is sampled, >= 1
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   i_start      in   one-cycle start pulse, honoured only while idle
//   i_abort      in   stop a sweep in progress (no done pulse)
//   o_fut_x      out  vector applied to the function (holds when not driving)
//   i_fut_y      in   function output
//   o_busy       out  sweep in progress
//   o_done       out  one-cycle pulse after the last vector is sampled
//   o_tt         out  captured truth table
//   o_ones       out  number of 1s captured in the current sweep
//
// Optional feature, enabled by defining TT_COMPARE_EN:
//   i_golden     in   expected truth table
//   o_mismatch   out  a captured bit differed from i_golden in this sweep
//   o_first_bad  out  lowest minterm that differed
// -----------------------------------------------------------------------------
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter  int N_IN   = 6,
  parameter  int SETTLE = 1,
  localparam int TT_W   = tt_w(N_IN),
  localparam int CNT_W  = cnt_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic [N_IN-1:0]  o_fut_x,
  input  logic             i_fut_y,
`ifdef TT_COMPARE_EN
  input  logic [TT_W-1:0]  i_golden,
  output logic             o_mismatch,
  output logic [N_IN-1:0]  o_first_bad,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [TT_W-1:0]  o_tt,
  output logic [CNT_W-1:0] o_ones
);

  // Elaboration-time guard on the parameter ranges.
  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX || SETTLE < SETTLE_MIN) begin : g_param_check
    $error("truth_table_sweeper: N_IN must be 1..8 and SETTLE must be >= 1");
  end

  state_e           r_state;
  state_e           w_next_state;
  logic [N_IN-1:0]  r_m;
  logic [TT_W-1:0]  r_tt;
  logic [CNT_W-1:0] r_ones;

  logic w_in_drive;
  logic w_accept;
  logic w_last;
  logic w_tc;
  logic w_sample;

  assign w_in_drive = (r_state == DRIVE);
  assign w_accept   = (r_state == IDLE) && i_start;
  assign w_last     = (r_m == {N_IN{1'b1}});
  // Abort wins over the sample: the minterm being sampled is not written.
  assign w_sample   = w_in_drive && !i_abort && w_tc;

  tt_settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept),
    .i_en    (w_in_drive && !i_abort),
    .o_tc    (w_tc)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = DRIVE;
        end
      end
      DRIVE: begin
        o_busy = 1'b1;
        if (i_abort) begin
          w_next_state = IDLE;
        end else if (w_sample && w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Minterm index, truth table and on-set count
  // ---------------------------------------------------------------------------
  // The terminal check precedes the increment, so r_m stops at 2^N_IN-1 and
  // never wraps. Because it is only touched by accept/sample, it also serves
  // as the held output vector outside DRIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m    <= '0;
      r_tt   <= '0;
      r_ones <= '0;
    end else if (w_accept) begin
      r_m    <= '0;
      r_tt   <= '0;
      r_ones <= '0;
    end else if (w_sample) begin
      r_tt[r_m] <= i_fut_y;
      r_ones    <= r_ones + CNT_W'(i_fut_y);
      if (!w_last) begin
        r_m <= r_m + N_IN'(1);
      end
    end
  end

  assign o_fut_x = r_m;
  assign o_tt    = r_tt;
  assign o_ones  = r_ones;

  // ---------------------------------------------------------------------------
  // Optional golden-table comparison: latches the first differing minterm.
  // ---------------------------------------------------------------------------
`ifdef TT_COMPARE_EN
  logic            r_mismatch;
  logic [N_IN-1:0] r_first_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch  <= 1'b0;
      r_first_bad <= '0;
    end else if (w_accept) begin
      r_mismatch  <= 1'b0;
      r_first_bad <= '0;
    end else if (w_sample && !r_mismatch && (i_fut_y != i_golden[r_m])) begin
      r_mismatch  <= 1'b1;
      r_first_bad <= r_m;
    end
  end

  assign o_mismatch  = r_mismatch;
  assign o_first_bad = r_first_bad;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Two sweepers (SETTLE=1 and SETTLE=3, both N_IN=6) driven by a truth-table
// function held in the bench. 'sel' routes start/abort to one of them and
// selects whose outputs are observed. Expected tables and counts come from
// the function itself and from window arithmetic on cycle indices.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_truth_table_sweeper;

  localparam int N_IN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        abort;
  logic        sel;
  logic [63:0] func;

  logic [5:0]  fut_x1, fut_x3;
  logic        fut_y1, fut_y3;
  logic        busy1, busy3, done1, done3;
  logic [63:0] tt1, tt3;
  logic [6:0]  ones1, ones3;
  logic        start1, start3, abort1, abort3;

  logic        obs_busy, obs_done;
  logic [5:0]  obs_fut_x;
  logic [63:0] obs_tt;
  logic [6:0]  obs_ones;

  int checks = 0;
  int errors = 0;

  // Function under test: a lookup into the bench's truth table.
  assign fut_y1 = func[fut_x1];
  assign fut_y3 = func[fut_x3];

  assign start1 = start && !sel;
  assign start3 = start && sel;
  assign abort1 = abort && !sel;
  assign abort3 = abort && sel;

  assign obs_busy  = sel ? busy3  : busy1;
  assign obs_done  = sel ? done3  : done1;
  assign obs_fut_x = sel ? fut_x3 : fut_x1;
  assign obs_tt    = sel ? tt3    : tt1;
  assign obs_ones  = sel ? ones3  : ones1;

`ifdef TT_COMPARE_EN
  logic [63:0] golden;
  logic        mismatch1, mismatch3, obs_mismatch;
  logic [5:0]  first_bad1, first_bad3, obs_first_bad;
  assign obs_mismatch  = sel ? mismatch3  : mismatch1;
  assign obs_first_bad = sel ? first_bad3 : first_bad1;
`endif

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start1),
    .i_abort     (abort1),
    .o_fut_x     (fut_x1),
    .i_fut_y     (fut_y1),
`ifdef TT_COMPARE_EN
    .i_golden    (golden),
    .o_mismatch  (mismatch1),
    .o_first_bad (first_bad1),
`endif
    .o_busy      (busy1),
    .o_done      (done1),
    .o_tt        (tt1),
    .o_ones      (ones1)
  );

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(3)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start3),
    .i_abort     (abort3),
    .o_fut_x     (fut_x3),
    .i_fut_y     (fut_y3),
`ifdef TT_COMPARE_EN
    .i_golden    (golden),
    .o_mismatch  (mismatch3),
    .o_first_bad (first_bad3),
`endif
    .o_busy      (busy3),
    .o_done      (done3),
    .o_tt        (tt3),
    .o_ones      (ones3)
  );

  // ---------------------------------------------------------------------------
  // Reference helpers
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] parity_table();
    logic [63:0] t;
    for (int m = 0; m < 64; m++) begin
      logic [5:0] mv;
      mv   = 6'(m);
      t[m] = ^mv;
    end
    return t;
  endfunction

  function automatic logic [6:0] count_ones(input logic [63:0] t);
    int n;
    n = 0;
    for (int m = 0; m < 64; m++) n += int'(t[m]);
    return 7'(n);
  endfunction

  function automatic int settle_of(input logic s);
    return s ? 3 : 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start; returns one sample point after the accepting edge (cycle 0).
  task automatic start_sweep();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs from cycle 0 of a sweep. sa/sb: cycles with an extra start pulse;
  // ab: cycle with abort; post: cycles observed after done before returning.
  task automatic run_sweep(input int settle, input int sa, input int sb, input int ab,
                           input int post, output int done_k, output int done_cnt,
                           output int xbad, output logic busy_at_done,
                           output logic [63:0] snap_tt, output logic [6:0] snap_ones);
    int limit;
    limit        = 64 * settle + 8;
    done_k       = -1;
    done_cnt     = 0;
    xbad         = 0;
    busy_at_done = 1'bx;
    snap_tt      = 'x;
    snap_ones    = 'x;
    for (int k = 0; k < limit; k++) begin
      if (obs_done === 1'b1) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k       = k;
          busy_at_done = obs_busy;
          snap_tt      = obs_tt;
          snap_ones    = obs_ones;
        end
      end
      if (done_k >= 0 && k >= done_k + post) break;
      if (done_k < 0 && obs_busy === 1'b1 && obs_fut_x !== 6'(k / settle)) xbad++;
      start = (k == sa) || (k == sb);
      abort = (k == ab);
      step();
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++; if ({fut_x1, busy1, done1} !== 8'd0) begin errors++; $display("FAIL reset_ctrl1: got %h exp 0", {fut_x1, busy1, done1}); end
    checks++; if ({tt1, ones1} !== 71'd0) begin errors++; $display("FAIL reset_data1: got %h exp 0", {tt1, ones1}); end
    checks++; if ({fut_x3, busy3, done3, tt3, ones3} !== 79'd0) begin errors++; $display("FAIL reset_all3: got %h exp 0", {fut_x3, busy3, done3, tt3, ones3}); end
    rst = 1'b0;
    repeat (2) step();
    checks++; if ({busy1, done1, busy3, done3} !== 4'd0) begin errors++; $display("FAIL idle_after_reset: got %b exp 0000", {busy1, done1, busy3, done3}); end
  endtask

  // Full sweep of 'func' on the selected DUT with the standard checks.
  task automatic full_sweep(input string name, input int sa, input int sb);
    int dk, dc, xb, settle;
    logic bd;
    logic [63:0] st;
    logic [6:0]  so;
    settle = settle_of(sel);
    start_sweep();
    checks++; if (obs_busy !== 1'b1 || obs_fut_x !== 6'd0) begin errors++; $display("FAIL %s_accept: busy=%b fut_x=%0d exp busy=1 fut_x=0", name, obs_busy, obs_fut_x); end
    run_sweep(settle, sa, sb, -1, 3, dk, dc, xb, bd, st, so);
    checks++; if (dk !== 64 * settle) begin errors++; $display("FAIL %s_done_cycle: got %0d exp %0d", name, dk, 64 * settle); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL %s_done_count: got %0d exp 1", name, dc); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b exp 0", name, bd); end
    checks++; if (xb !== 0) begin errors++; $display("FAIL %s_fut_x_windows: %0d bad cycles exp 0", name, xb); end
    checks++; if (st !== func) begin errors++; $display("FAIL %s_tt: got %h exp %h", name, st, func); end
    checks++; if (so !== count_ones(func)) begin errors++; $display("FAIL %s_ones: got %0d exp %0d", name, so, count_ones(func)); end
    checks++; if (obs_tt !== func || obs_ones !== count_ones(func) || obs_busy !== 1'b0) begin errors++; $display("FAIL %s_hold: tt=%h ones=%0d busy=%b", name, obs_tt, obs_ones, obs_busy); end
  endtask

  task automatic test_parity();
    sel  = 1'b0;
    func = parity_table();
    checks++; if (func !== 64'h6996966996696996) begin errors++; $display("FAIL parity_model: got %h exp 6996966996696996", func); end
    full_sweep("parity", -1, -1);
    checks++; if (tt1 !== 64'h6996966996696996 || ones1 !== 7'd32) begin errors++; $display("FAIL parity_const: tt=%h ones=%0d exp 6996966996696996/32", tt1, ones1); end
  endtask

  task automatic test_settle();
    sel  = 1'b1;
    func = 64'd0;
    full_sweep("settle3", -1, -1);
    checks++; if (fut_x3 !== 6'd63) begin errors++; $display("FAIL settle3_hold_x: got %0d exp 63", fut_x3); end
  endtask

  task automatic test_busy_start();
    sel  = 1'b0;
    func = parity_table();
    full_sweep("busy_start", 5, 40);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      sel  = i[0];
      func = {$urandom, $urandom};
      full_sweep($sformatf("random%0d", i), -1, -1);
    end
  endtask

  // Abort during cycle ka: minterms whose window ended before ka are kept.
  task automatic abort_case(input string name, input logic s, input int ka, input logic [63:0] f);
    int dk, dc, xb, settle, kept;
    logic bd;
    logic [63:0] st, exp_tt;
    logic [6:0]  so;
    sel    = s;
    func   = f;
    settle = settle_of(s);
    kept   = ka / settle;
    exp_tt = f & ((64'd1 << kept) - 64'd1);
    start_sweep();
    run_sweep(settle, -1, -1, ka, 3, dk, dc, xb, bd, st, so);
    checks++; if (dc !== 0) begin errors++; $display("FAIL %s_no_done: got %0d pulses exp 0", name, dc); end
    checks++; if (obs_busy !== 1'b0 || obs_fut_x !== 6'(kept)) begin errors++; $display("FAIL %s_state: busy=%b fut_x=%0d exp 0/%0d", name, obs_busy, obs_fut_x, kept); end
    checks++; if (obs_tt !== exp_tt || obs_ones !== count_ones(exp_tt)) begin errors++; $display("FAIL %s_partial: tt=%h ones=%0d exp %h/%0d", name, obs_tt, obs_ones, exp_tt, count_ones(exp_tt)); end
  endtask

  task automatic test_abort();
    abort_case("abort10", 1'b0, 10, {64{1'b1}});
    checks++; if (tt1 !== 64'h3FF || ones1 !== 7'd10) begin errors++; $display("FAIL abort10_const: tt=%h ones=%0d exp 3ff/10", tt1, ones1); end
    for (int i = 0; i < 3; i++) begin
      logic s;
      s = i[0];
      abort_case($sformatf("abort_rand%0d", i), s, int'($urandom_range(1, 64 * settle_of(s) - 2)), {$urandom, $urandom});
    end
  endtask

  task automatic test_back_to_back();
    int dk, dc, xb;
    logic bd;
    logic [63:0] st;
    logic [6:0]  so;
    sel  = 1'b0;
    func = {$urandom, $urandom};
    start_sweep();
    // start during the done cycle (cycle 64) must be ignored
    run_sweep(1, 64, -1, -1, 1, dk, dc, xb, bd, st, so);
    checks++; if (dk !== 64 || obs_busy !== 1'b0) begin errors++; $display("FAIL b2b_done_ignore: done_k=%0d busy=%b exp 64/0", dk, obs_busy); end
    checks++; if (st !== func) begin errors++; $display("FAIL b2b_first_tt: got %h exp %h", st, func); end
    // the following idle cycle accepts
    func = {$urandom, $urandom};
    full_sweep("b2b_second", -1, -1);
  endtask

  task automatic test_reset_mid();
    sel  = 1'b0;
    func = parity_table();
    start_sweep();
    repeat (20) step();
    checks++; if (fut_x1 !== 6'd20 || busy1 !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: fut_x=%0d busy=%b exp 20/1", fut_x1, busy1); end
    rst = 1'b1;
    #1;
    checks++; if ({fut_x1, busy1, done1, tt1, ones1} !== 79'd0) begin errors++; $display("FAIL rst_mid_async: got %h exp 0", {fut_x1, busy1, done1, tt1, ones1}); end
    step();
    rst = 1'b0;
    step();
    full_sweep("rst_mid_resweep", -1, -1);
  endtask

`ifdef TT_COMPARE_EN
  task automatic compare_case(input string name, input logic s, input logic [63:0] f, input logic [63:0] g);
    int exp_bad;
    sel    = s;
    func   = f;
    golden = g;
    exp_bad = -1;
    for (int m = 63; m >= 0; m--) if (f[m] != g[m]) exp_bad = m;
    start_sweep();
    while (obs_done !== 1'b1 && obs_busy === 1'b1) step();
    checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b exp 1", name, obs_done); end
    checks++; if (obs_mismatch !== (exp_bad >= 0)) begin errors++; $display("FAIL %s_mismatch: got %b exp %b", name, obs_mismatch, exp_bad >= 0); end
    if (exp_bad >= 0) begin
      checks++; if (obs_first_bad !== 6'(exp_bad)) begin errors++; $display("FAIL %s_first_bad: got %0d exp %0d", name, obs_first_bad, exp_bad); end
    end
    repeat (2) step();
  endtask

  task automatic test_compare();
    logic [63:0] p;
    p = parity_table();
    compare_case("cmp_flip", 1'b0, p, p ^ (64'd1 << 5) ^ (64'd1 << 9));
    checks++; if (first_bad1 !== 6'd5) begin errors++; $display("FAIL cmp_flip_const: got %0d exp 5", first_bad1); end
    compare_case("cmp_exact", 1'b0, p, p);
    for (int i = 0; i < 2; i++) begin
      logic [63:0] f;
      f = {$urandom, $urandom};
      compare_case($sformatf("cmp_rand%0d", i), i[0], f, f ^ (64'd1 << $urandom_range(0, 63)));
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sel   = 1'b0;
    func  = 64'd0;
`ifdef TT_COMPARE_EN
    golden = 64'd0;
`endif
    test_reset();
    test_parity();
    test_settle();
    test_busy_start();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef TT_COMPARE_EN
    test_compare();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
